btn_press_classifier: RTL and testbench

//   Consumes the debounced button outputs (db_level, db_tick) and classifies each press as

---
 rtl/btn_press_classifier.sv | 116 +++++++++++
 tb/tb_btn_press_classifier.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses as short or long, with optional auto-repeat while held.
// Optional feature macro: BTN_AUTOREPEAT_EN enables repeat_tick; when undefined, repeat_tick is tied low.
module btn_press_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CW            = 26,
  parameter int PCW           = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           db_level,
  input  logic           db_tick,
  output logic           short_tick,
  output logic           long_tick,
  output logic           repeat_tick,
  output logic           held,
  output logic [PCW-1:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           short_nxt, long_nxt;
  logic [PCW-1:0] count_nxt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  logic repeat_nxt;

  always_ff @(posedge clk) begin
    if (reset) repeat_tick <= 1'b0;
    else       repeat_tick <= repeat_nxt;
  end
`else
  assign repeat_tick = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      short_tick  <= short_nxt;
      long_tick   <= long_nxt;
      held        <= (state_nxt != IDLE);
      press_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    count_nxt  = press_count;
`ifdef BTN_AUTOREPEAT_EN
    repeat_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Only the debouncer's press event starts a press; a bare high level does not.
        if (db_tick) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        // Release wins over long expiry in the same cycle.
        if (!db_level) begin
          short_nxt = 1'b1;
          count_nxt = press_count + 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          count_nxt = press_count + 1'b1;
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!db_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REPEAT_LAST) begin
            repeat_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4, PCW=8.
// Repeat expectations follow BTN_AUTOREPEAT_EN as defined for the build.
module tb_btn_press_classifier;

  localparam int L   = 8;
  localparam int R   = 4;
  localparam int PCW = 8;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           db_level;
  logic           db_tick;
  logic           short_tick;
  logic           long_tick;
  logic           repeat_tick;
  logic           held;
  logic [PCW-1:0] press_count;

  int checks   = 0;
  int failures = 0;

  btn_press_classifier #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CW           (8),
    .PCW          (PCW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_level   (db_level),
    .db_tick    (db_tick),
    .short_tick (short_tick),
    .long_tick  (long_tick),
    .repeat_tick(repeat_tick),
    .held       (held),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    db_level = 1'b0;
    db_tick  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One press: db_tick at cycle 0 (if do_tick), optional extra db_tick, db_level high for cycles 0..rel-1.
  // Outputs {short,long,repeat,held} are compared every cycle; rst_cyc >= 0 pulses reset in that cycle.
  task automatic run_press(input string name, input bit do_tick, input int rel, input int ncyc,
                           input int extra_tick, input int rst_cyc, input int exp_cnt);
    logic [3:0] got, exp;
    bit act, s_e, l_e, r_e, h_e;
    do_reset();
    for (int i = 0; i < ncyc; i++) begin
      db_tick  = (do_tick && i == 0) || (i == extra_tick);
      db_level = (i < rel);
      reset    = (i == rst_cyc);
      @(negedge clk);
      act = do_tick && (rst_cyc < 0 || i <= rst_cyc);
      h_e = act && i >= 1 && i <= rel;
      s_e = act && rel <= L && i == rel + 1;
      l_e = act && rel > L && i == L + 1;
      r_e = AR && act && rel > L && i >= L + 1 + R && ((i - L - 1) % R) == 0 && i <= rel;
      got = {short_tick, long_tick, repeat_tick, held};
      exp = {s_e, l_e, r_e, h_e};
      chk($sformatf("%s_c%0d_slrh", name, i), 32'(got), 32'(exp));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    chk($sformatf("%s_press_count", name), 32'(press_count), 32'(exp_cnt));
  endtask

  task automatic run_wrap();
    int shorts = 0;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      db_tick  = 1'b1;
      db_level = 1'b1;
      @(negedge clk);
      if (short_tick) shorts++;
      if (p == 255) chk("wrap_count_255", 32'(press_count), 32'd255);
      @(posedge clk);
      #1;
      db_tick  = 1'b0;
      db_level = 1'b0;
      @(negedge clk);
      if (short_tick) shorts++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    if (short_tick) shorts++;
    chk("wrap_count_0", 32'(press_count), 32'd0);
    chk("wrap_short_ticks", 32'(shorts), 32'd256);
    @(posedge clk);
    #1;
    chk("wrap_held_idle", 32'(held), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    db_level = 1'b0;
    db_tick  = 1'b0;
    do_reset();
    @(negedge clk);
    chk("reset_slrh", 32'({short_tick, long_tick, repeat_tick, held}), 32'd0);
    chk("reset_count", 32'(press_count), 32'd0);
    @(posedge clk);
    #1;

    run_press("short",      1'b1, 4,  10, -1, -1, 1);
    run_press("long_hold",  1'b1, 20, 24, -1, -1, 1);
    run_press("edge_short", 1'b1, 8,  12, -1, -1, 1);
    run_press("edge_long",  1'b1, 9,  14, -1, -1, 1);
    run_press("rst_held",   1'b1, 30, 20, -1, 11, 0);
    run_press("extra_tick", 1'b1, 12, 14,  3, -1, 1);
    run_press("level_only", 1'b0, 6,  10, -1, -1, 0);
    run_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
